t02_keypad_scan: RTL and testbench

//  Drives the row strobes of a 4x4 matrix keypad and reads back the column

---
 rtl/t02_keypad_scan.sv | 153 +++++++++++++++
 tb/tb_t02_keypad_scan.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/t02_keypad_scan.sv
// 4x4 matrix keypad scanner: walks active-low row strobes, debounces whole frames, emits single-key press events.
// Latency: a key press is accepted after STABLE_CNT+1 identical frames; key_valid follows 2 cycles after that frame's gap cycle.
// Backpressure: none; key_valid is a one-cycle pulse and key_code holds until the next event.
//
// Ports:
//   clk, nrst         clock and asynchronous active-low reset
//   en                scan enable; low idles the scanner and clears all key state
//   col_n[3:0]        keypad columns (active-low, asynchronous, pulled up)
//   row_n[3:0]        row strobes (active-low, at most one low)
//   key_valid         one-cycle pulse when a single key is newly accepted
//   key_code[3:0]     {row, col} of the accepted key
//   key_held          accepted key map is non-zero
//   multi_key         accepted key map has more than one key
module t02_keypad_scan #(
  parameter int SCAN_DIV   = 12000,
  parameter int STABLE_CNT = 10
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       en,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       multi_key
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int STB_W = $clog2(STABLE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_CNT);

  typedef enum logic [1:0] {IDLE, SCAN, FRAME} state_t;

  state_t           state_q, state_d;
  logic [3:0]       col_s1, col_sync;
  logic [1:0]       row_q;
  logic [DIV_W-1:0] div_q;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [15:0]      frame_q, prev_q, accepted_q, acc_old_q;
  logic             accept;
  logic             acc_onehot;
  logic [3:0]       acc_idx;

  // Columns are asynchronous to clk; nothing downstream sees col_n directly.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      col_s1   <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_s1   <= col_n;
      col_sync <= col_s1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    row_n   = 4'hF;
    case (state_q)
      IDLE:  if (en) state_d = SCAN;
      SCAN: begin
        row_n = ~(4'b0001 << row_q);
        if (div_q == DIV_LAST && row_q == 2'd3) state_d = FRAME;
      end
      FRAME: state_d = SCAN;
      default: state_d = IDLE;
    endcase
    if (!en) state_d = IDLE;
  end

  // Frame-level debounce: only the transition into saturation may update the
  // accepted map, so a map that stays stable is not re-accepted every frame.
  always_comb begin
    stable_d = '0;
    if (frame_q == prev_q)
      stable_d = (stable_q == STB_MAX) ? STB_MAX : stable_q + STB_W'(1);
    accept = (stable_q != STB_MAX) && (stable_d == STB_MAX) && (frame_q != accepted_q);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      row_q      <= '0;
      div_q      <= '0;
      stable_q   <= '0;
      frame_q    <= '0;
      prev_q     <= '0;
      accepted_q <= '0;
    end else if (!en) begin
      row_q      <= '0;
      div_q      <= '0;
      stable_q   <= '0;
      frame_q    <= '0;
      prev_q     <= '0;
      accepted_q <= '0;
    end else begin
      case (state_q)
        SCAN: begin
          if (div_q == DIV_LAST) begin
            // Sample at the last cycle of the row so the columns have settled.
            frame_q[{row_q, 2'b00} +: 4] <= ~col_sync;
            div_q <= '0;
            row_q <= row_q + 2'd1;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        FRAME: begin
          stable_q <= stable_d;
          prev_q   <= frame_q;
          if (accept) accepted_q <= frame_q;
          row_q <= '0;
          div_q <= '0;
        end
        default: begin
          row_q <= '0;
          div_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    acc_idx = '0;
    for (int i = 0; i < 16; i++)
      if (accepted_q[i]) acc_idx = 4'(i);
    acc_onehot = (accepted_q != '0) && ((accepted_q & (accepted_q - 16'd1)) == '0);
  end

  // Events only fire from an all-released map to exactly one key, so a held
  // key, an added key or a key-to-key jump never produces a repeat.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_old_q <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      acc_old_q <= accepted_q;
      key_valid <= (acc_old_q == '0) && acc_onehot;
      if ((acc_old_q == '0) && acc_onehot) key_code <= acc_idx;
      key_held  <= (accepted_q != '0);
      multi_key <= (accepted_q != '0) && !acc_onehot;
    end
  end

endmodule

// File: tb/tb_t02_keypad_scan.sv
// Bench for t02_keypad_scan with SCAN_DIV=4, STABLE_CNT=2 (17-cycle frames).
// A behavioural keypad pulls columns low for pressed keys on the strobed row.
// Expected key events are queued at stimulus time and popped by a monitor.
module tb_t02_keypad_scan;

  localparam int FR = 17;

  logic       clk = 1'b0;
  logic       nrst;
  logic       en;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic       multi_key;
  logic [15:0] pressed;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  t02_keypad_scan #(.SCAN_DIV(4), .STABLE_CNT(2)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .en        (en),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its column to a low row strobe.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every key_valid pulse must match a queued expectation.
  always @(negedge clk) begin
    if (nrst && key_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_key_valid: got code %0h expected no event", key_code);
      end else begin
        check("key_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  typedef struct {
    logic [15:0] keys;
    int          frames;
    bit          ev;
    logic [3:0]  code;
    bit          held;
    bit          multi;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit found;

    tbl[0] = '{16'h0000, 4, 1'b0, 4'h0, 1'b0, 1'b0};  // idle scan, nothing pressed
    tbl[1] = '{16'h0200, 5, 1'b1, 4'h9, 1'b1, 1'b0};  // row2/col1
    tbl[2] = '{16'h0201, 5, 1'b0, 4'h0, 1'b1, 1'b1};  // add key 0: no event
    tbl[3] = '{16'h0000, 5, 1'b0, 4'h0, 1'b0, 1'b0};  // release all
    tbl[4] = '{16'h0001, 5, 1'b1, 4'h0, 1'b1, 1'b0};  // key 0 alone
    tbl[5] = '{16'h8000, 5, 1'b0, 4'h0, 1'b1, 1'b0};  // jump to key 15 without release
    tbl[6] = '{16'h0000, 5, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[7] = '{16'h0010, 5, 1'b1, 4'h4, 1'b1, 1'b0};  // row1/col0
    tbl[8] = '{16'h0000, 5, 1'b0, 4'h0, 1'b0, 1'b0};

    nrst = 1'b0; en = 1'b0; pressed = '0;
    repeat (3) @(negedge clk);
    check("rst_row_n", {28'd0, row_n}, 32'hF);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_code", {28'd0, key_code}, 32'd0);
    check("rst_key_held", {31'd0, key_held}, 32'd0);
    check("rst_multi_key", {31'd0, multi_key}, 32'd0);

    nrst = 1'b1;
    @(negedge clk);
    en = 1'b1;
    // One full frame: E,D,B,7 for 4 cycles each, then F for the gap.
    for (int k = 0; k < FR; k++) begin
      logic [3:0] exp_row;
      @(negedge clk);
      exp_row = (k < 16) ? ~(4'b0001 << (k / 4)) : 4'hF;
      check($sformatf("walk_row_n[%0d]", k), {28'd0, row_n}, {28'd0, exp_row});
    end

    for (int v = 0; v < 9; v++) begin
      pressed = tbl[v].keys;
      if (tbl[v].ev) exp_q.push_back(tbl[v].code);
      repeat (tbl[v].frames * FR) @(negedge clk);
      check($sformatf("vec%0d_drained", v), exp_q.size(), 32'd0);
      check($sformatf("vec%0d_key_held", v), {31'd0, key_held}, {31'd0, tbl[v].held});
      check($sformatf("vec%0d_multi_key", v), {31'd0, multi_key}, {31'd0, tbl[v].multi});
    end

    // Bouncing key: a different map every frame never reaches stability.
    for (int i = 0; i < 6; i++) begin
      pressed = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      repeat (FR) @(negedge clk);
    end
    repeat (3 * FR) @(negedge clk);
    check("bounce_key_held", {31'd0, key_held}, 32'd0);
    check("bounce_drained", exp_q.size(), 32'd0);

    // Disable mid-row with a key held, then re-enable.
    pressed = 16'h0200;
    exp_q.push_back(4'h9);
    repeat (5 * FR) @(negedge clk);
    check("en_pre_drained", exp_q.size(), 32'd0);
    check("en_pre_key_held", {31'd0, key_held}, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (row_n == 4'hB) found = 1'b1;
    end
    check("wait_row2", {31'd0, found}, 32'd1);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en_off_row_n", {28'd0, row_n}, 32'hF);
    @(negedge clk);
    check("en_off_key_held", {31'd0, key_held}, 32'd0);
    check("en_off_multi_key", {31'd0, multi_key}, 32'd0);
    check("en_off_row_n_idle", {28'd0, row_n}, 32'hF);
    repeat (3) @(negedge clk);
    en = 1'b1;
    exp_q.push_back(4'h9);
    repeat (5 * FR) @(negedge clk);
    check("reen_drained", exp_q.size(), 32'd0);
    check("reen_key_held", {31'd0, key_held}, 32'd1);

    // Asynchronous reset mid-scan, between clock edges.
    repeat (6) @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check("arst_row_n", {28'd0, row_n}, 32'hF);
    check("arst_key_valid", {31'd0, key_valid}, 32'd0);
    check("arst_key_code", {28'd0, key_code}, 32'd0);
    check("arst_key_held", {31'd0, key_held}, 32'd0);
    check("arst_multi_key", {31'd0, multi_key}, 32'd0);
    pressed = '0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (4 * FR) @(negedge clk);
    check("final_drained", exp_q.size(), 32'd0);
    check("final_key_held", {31'd0, key_held}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
